// File: rtl/vga_pkg.sv
// Shared 800x600@60 Hz raster constants and types for the display pipeline.
package vga_pkg;

  localparam int unsigned COUNT_W = 11;
  localparam int unsigned LEVEL_W = 4;

  localparam int unsigned VGA_H_ACTIVE     = 800;
  localparam int unsigned VGA_H_SYNC_START = 840;
  localparam int unsigned VGA_H_SYNC_END   = 968;
  localparam int unsigned VGA_H_TOTAL      = 1056;

  localparam int unsigned VGA_V_ACTIVE     = 600;
  localparam int unsigned VGA_V_SYNC_START = 601;
  localparam int unsigned VGA_V_SYNC_END   = 605;
  localparam int unsigned VGA_V_TOTAL      = 628;

  localparam logic VGA_SYNC_POL = 1'b1;

  typedef logic [COUNT_W-1:0] count_t;
  typedef logic [LEVEL_W-1:0] level_t;

  // Half-open window test [lo, hi) used for the sync pulses.
  function automatic logic inWindow(count_t value, count_t lo, count_t hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulus counter for one raster axis; wraps to zero after MODULUS-1 when enabled.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned MODULUS = VGA_H_TOTAL
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  output count_t count_o,
  output logic   wrap_o
);

  localparam count_t LAST = count_t'(MODULUS - 1);

  count_t count_q;
  count_t count_d;

  // Next count: hold when disabled, wrap to zero at the last position.
  always_comb begin
    wrap_o  = en_i && (count_q == LAST);
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + count_t'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator: counters, registered sync/blank decode
// and a level value that only changes at frame boundaries.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
  parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
  parameter int unsigned H_SYNC_END   = VGA_H_SYNC_END,
  parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
  parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
  parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
  parameter int unsigned V_SYNC_END   = VGA_V_SYNC_END,
  parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
  parameter logic        SYNC_POL     = VGA_SYNC_POL
) (
  input  logic   clk,
  input  logic   rst,
  input  level_t level_in,
  output count_t hcount_out,
  output count_t vcount_out,
  output logic   h_sync_out,
  output logic   v_sync_out,
  output logic   h_blank_out,
  output logic   v_blank_out,
  output logic   frame_start,
  output level_t level_out,
  output logic   level_changed
);

  localparam logic SYNC_IDLE = ~SYNC_POL;

  count_t hCount;
  count_t vCount;
  logic   hWrap;
  logic   vWrap;

  // The last pixel of a frame is when the vertical counter wraps.
  logic   firstPixel_q;

  count_t hcount_q, hcount_d;
  count_t vcount_q, vcount_d;
  logic   hSync_q, hSync_d;
  logic   vSync_q, vSync_d;
  logic   hBlank_q, hBlank_d;
  logic   vBlank_q, vBlank_d;
  logic   frameStart_q, frameStart_d;
  level_t level_q, level_d;
  logic   levelChanged_q, levelChanged_d;

  vga_axis_counter #(.MODULUS(H_TOTAL)) uHCounter (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .count_o (hCount),
    .wrap_o  (hWrap)
  );

  vga_axis_counter #(.MODULUS(V_TOTAL)) uVCounter (
    .clk     (clk),
    .rst     (rst),
    .en_i    (hWrap),
    .count_o (vCount),
    .wrap_o  (vWrap)
  );

  // Flag that the counters sit at (0,0): set out of reset and after the last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      firstPixel_q <= 1'b1;
    end else begin
      firstPixel_q <= vWrap;
    end
  end

  // Decode the current counter position into the next output bundle.
  always_comb begin
    hcount_d       = hCount;
    vcount_d       = vCount;
    hBlank_d       = hCount >= count_t'(H_ACTIVE);
    vBlank_d       = vCount >= count_t'(V_ACTIVE);
    hSync_d        = inWindow(hCount, count_t'(H_SYNC_START), count_t'(H_SYNC_END))
                     ? SYNC_POL : SYNC_IDLE;
    vSync_d        = inWindow(vCount, count_t'(V_SYNC_START), count_t'(V_SYNC_END))
                     ? SYNC_POL : SYNC_IDLE;
    frameStart_d   = firstPixel_q;
    level_d        = level_q;
    levelChanged_d = 1'b0;
    if (firstPixel_q) begin
      level_d        = level_in;
      levelChanged_d = (level_in != level_q);
    end
  end

  // Output register stage; syncs idle at the inactive polarity in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q       <= '0;
      vcount_q       <= '0;
      hSync_q        <= SYNC_IDLE;
      vSync_q        <= SYNC_IDLE;
      hBlank_q       <= 1'b0;
      vBlank_q       <= 1'b0;
      frameStart_q   <= 1'b0;
      level_q        <= '0;
      levelChanged_q <= 1'b0;
    end else begin
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      hSync_q        <= hSync_d;
      vSync_q        <= vSync_d;
      hBlank_q       <= hBlank_d;
      vBlank_q       <= vBlank_d;
      frameStart_q   <= frameStart_d;
      level_q        <= level_d;
      levelChanged_q <= levelChanged_d;
    end
  end

  assign hcount_out    = hcount_q;
  assign vcount_out    = vcount_q;
  assign h_sync_out    = hSync_q;
  assign v_sync_out    = vSync_q;
  assign h_blank_out   = hBlank_q;
  assign v_blank_out   = vBlank_q;
  assign frame_start   = frameStart_q;
  assign level_out     = level_q;
  assign level_changed = levelChanged_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: a default-geometry instance plus two
// small-geometry instances (both sync polarities) against a position model.
module tb_vga_timing;
  import vga_pkg::*;

  // Small raster so several whole frames fit in a short run.
  localparam int S_HA = 16, S_HSS = 18, S_HSE = 22, S_HT = 26;
  localparam int S_VA = 10, S_VSS = 11, S_VSE = 13, S_VT = 15;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int D_FRAME = 1056 * 628;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  level_t levelIn = '0;

  int errors = 0;
  int checks = 0;

  count_t hcS, vcS, hcP, vcP, hcD, vcD;
  logic   hsS, vsS, hbS, vbS, fsS, chS;
  logic   hsP, vsP, hbP, vbP, fsP, chP;
  logic   hsD, vsD, hbD, vbD, fsD, chD;
  level_t lvS, lvP, lvD;

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE(S_HA), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE), .H_TOTAL(S_HT),
    .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE), .V_TOTAL(S_VT),
    .SYNC_POL(1'b1)
  ) dutS (
    .clk(clk), .rst(rst), .level_in(levelIn),
    .hcount_out(hcS), .vcount_out(vcS), .h_sync_out(hsS), .v_sync_out(vsS),
    .h_blank_out(hbS), .v_blank_out(vbS), .frame_start(fsS),
    .level_out(lvS), .level_changed(chS)
  );

  vga_timing #(
    .H_ACTIVE(S_HA), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE), .H_TOTAL(S_HT),
    .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE), .V_TOTAL(S_VT),
    .SYNC_POL(1'b0)
  ) dutP (
    .clk(clk), .rst(rst), .level_in(levelIn),
    .hcount_out(hcP), .vcount_out(vcP), .h_sync_out(hsP), .v_sync_out(vsP),
    .h_blank_out(hbP), .v_blank_out(vbP), .frame_start(fsP),
    .level_out(lvP), .level_changed(chP)
  );

  vga_timing dutD (
    .clk(clk), .rst(rst), .level_in(levelIn),
    .hcount_out(hcD), .vcount_out(vcD), .h_sync_out(hsD), .v_sync_out(vsD),
    .h_blank_out(hbD), .v_blank_out(vbD), .frame_start(fsD),
    .level_out(lvD), .level_changed(chD)
  );

  // Model state: edges since reset release and the level each geometry latched.
  int     cnt = 0;
  level_t lvlS = '0, lvlD = '0;
  logic   chgS = 1'b0, chgD = 1'b0;

  // Advance the model; a frame begins every FRAME edges starting with edge 1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  = 0;
      lvlS = '0;
      lvlD = '0;
      chgS = 1'b0;
      chgD = 1'b0;
    end else begin
      cnt = cnt + 1;
      if ((cnt - 1) % S_FRAME == 0) begin
        chgS = (levelIn != lvlS);
        lvlS = levelIn;
      end
      if ((cnt - 1) % D_FRAME == 0) begin
        chgD = (levelIn != lvlD);
        lvlD = levelIn;
      end
    end
  end

  // Expected output bundle for edge number c of a raster with the given geometry.
  function automatic logic [31:0] model(int ht, int ha, int hss, int hse,
                                        int vt, int va, int vss, int vse,
                                        logic pol, int c, level_t lv, logic ch);
    int   p, h, v;
    logic fs;
    if (c == 0) begin
      return {11'd0, 11'd0, ~pol, ~pol, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    end
    p  = (c - 1) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    fs = (p == 0);
    return {11'(h), 11'(v),
            (h >= hss && h < hse) ? pol : ~pol,
            (v >= vss && v < vse) ? pol : ~pol,
            h >= ha, v >= va, fs, lv, fs & ch};
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, cnt, act, exp);
    end
  endtask

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", name, cnt, act, exp);
    end
  endtask

  // Every cycle, compare all three instances against the model.
  always @(negedge clk) begin
    checkOutput("bundleS", {hcS, vcS, hsS, vsS, hbS, vbS, fsS, lvS, chS},
                model(S_HT, S_HA, S_HSS, S_HSE, S_VT, S_VA, S_VSS, S_VSE,
                      1'b1, cnt, lvlS, chgS));
    checkOutput("bundleP", {hcP, vcP, hsP, vsP, hbP, vbP, fsP, lvP, chP},
                model(S_HT, S_HA, S_HSS, S_HSE, S_VT, S_VA, S_VSS, S_VSE,
                      1'b0, cnt, lvlS, chgS));
    checkOutput("bundleD", {hcD, vcD, hsD, vsD, hbD, vbD, fsD, lvD, chD},
                model(1056, 800, 840, 968, 628, 600, 601, 605,
                      1'b1, cnt, lvlD, chgD));
  end

  // Run negedge by negedge until the model reaches edge target, optionally
  // changing level_in at random; a missed target counts as a failure.
  task automatic applyStimulus(int target, bit doRandom);
    int guard = 0;
    while (cnt < target) begin
      if (doRandom && $urandom_range(0, 7) == 0) begin
        levelIn = level_t'($urandom_range(0, 15));
      end
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        checks++;
        errors++;
        $display("[TB] FAIL timeout waiting for edge %0d: got %0d", target, cnt);
        break;
      end
    end
  endtask

  initial begin
    levelIn = 4'd2;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    checkValue("resetHcount", 32'(hcS), 0);
    checkValue("resetSyncPol1", 32'(hsS), 0);
    checkValue("resetSyncPol0", 32'(hsP), 1);
    checkValue("resetVsyncPol0", 32'(vsP), 1);
    checkValue("resetLevel", 32'(lvS), 0);

    rst = 1'b0;
    applyStimulus(1, 1'b0);
    checkValue("firstFrameStart", 32'(fsS), 1);
    checkValue("firstHcount", 32'(hcS), 0);
    checkValue("firstLevel", 32'(lvS), 2);
    checkValue("firstChanged", 32'(chS), 1);

    applyStimulus(100, 1'b0);
    levelIn = 4'd5;
    applyStimulus(200, 1'b0);
    checkValue("levelHeldMidFrame", 32'(lvS), 2);
    applyStimulus(261, 1'b0);
    checkValue("vblankAt10", 32'(vbS), 1);
    applyStimulus(287, 1'b0);
    checkValue("vsyncAt11", 32'(vsS), 1);
    checkValue("vsyncAt11Pol0", 32'(vsP), 0);
    applyStimulus(391, 1'b0);
    checkValue("secondFrameStart", 32'(fsS), 1);
    checkValue("levelNewFrame", 32'(lvS), 5);
    checkValue("changedNewFrame", 32'(chS), 1);
    applyStimulus(392, 1'b0);
    checkValue("changedOneCycle", 32'(chS), 0);
    applyStimulus(781, 1'b0);
    checkValue("thirdFrameStart", 32'(fsS), 1);
    checkValue("sameLevelNoChange", 32'(chS), 0);

    applyStimulus(800, 1'b0);
    checkValue("hblankBefore800", 32'(hbD), 0);
    applyStimulus(801, 1'b0);
    checkValue("hcountAt800", 32'(hcD), 800);
    checkValue("hblankAt800", 32'(hbD), 1);
    applyStimulus(841, 1'b0);
    checkValue("hsyncAt840", 32'(hsD), 1);
    applyStimulus(969, 1'b0);
    checkValue("hsyncAt968", 32'(hsD), 0);
    applyStimulus(1056, 1'b0);
    checkValue("hcountLast", 32'(hcD), 1055);
    applyStimulus(1057, 1'b0);
    checkValue("hcountWrap", 32'(hcD), 0);
    checkValue("vcountStep", 32'(vcD), 1);

    applyStimulus(3669, 1'b1);
    checkValue("preResetHcount", 32'(hcD), 500);
    #2 rst = 1'b1;
    #1;
    checkValue("asyncHcountD", 32'(hcD), 0);
    checkValue("asyncVcountS", 32'(vcS), 0);
    checkValue("asyncSyncPol0", 32'(hsP), 1);
    checkValue("asyncFrameStart", 32'(fsS), 0);
    checkValue("asyncLevel", 32'(lvS), 0);
    @(negedge clk);
    levelIn = 4'd9;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1'b0);
    checkValue("restartFrameStart", 32'(fsS), 1);
    checkValue("restartLevel", 32'(lvD), 9);
    checkValue("restartChanged", 32'(chS), 1);

    applyStimulus(6000, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
